// File: rtl/fpu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_arb_pkg
// Description : Shared types and constants for the fpu_arb arbiter slice:
//               sequencer state encoding and unit data/flag widths.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_arb_pkg;

    localparam int FPU_DATA_W = 32;
    localparam int FPU_FLAG_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage : fpu_arb_pkg
`default_nettype wire

// File: rtl/fpu_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : fpu_rr_pick
// Description : Combinational round-robin picker. Returns the first asserted
//               request at or after index (last+1) mod NREQ, wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_rr_pick
    import fpu_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    // Scan from the slot just after the previous winner; the first hit wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (int'(last) + k) % NREQ;
            if (!any && req[c]) begin
                any = 1'b1;
                idx = IDX_W'(c);
            end
        end
    end

endmodule : fpu_rr_pick
`default_nettype wire

// File: rtl/fpu_arb.sv
`default_nettype none
// ============================================================================
// Module      : fpu_arb
// Description : Round-robin arbiter/sequencer sharing one run/stall style
//               floating-point unit among NREQ requesters. Latches the
//               winner's operand, holds run until stall drops, captures the
//               result/flags and returns a one-cycle ack.
//               Optional macro FPU_ARB_TIMEOUT_EN adds a RUN-cycle watchdog
//               and a timeout output.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_arb
    import fpu_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req,
    input  logic [FPU_DATA_W*NREQ-1:0] x_in,
    output logic [NREQ-1:0]            ack,
    output logic [FPU_DATA_W-1:0]      z_out,
    output logic [FPU_FLAG_W-1:0]      flags_out,
    output logic                       fpu_run,
    output logic [FPU_DATA_W-1:0]      fpu_x,
    input  logic                       fpu_stall,
    input  logic [FPU_DATA_W-1:0]      fpu_z,
    input  logic [FPU_FLAG_W-1:0]      fpu_flags,
    output logic                       busy
`ifdef FPU_ARB_TIMEOUT_EN
    ,
    output logic                       timeout
`endif
);

    localparam int c_idx_w = $clog2(NREQ);
    localparam int c_cnt_w = 16;

    // Elaboration guard on the supported parameter ranges.
    generate
        if ((NREQ < 2) || (NREQ > 8) || (TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_param_check
            $error("fpu_arb: NREQ must be 2..8 and TIMEOUT 1..65535");
        end
    endgenerate

    state_t                r_state;
    state_t                w_next;
    logic [c_idx_w-1:0]    r_grant;
    logic [c_idx_w-1:0]    r_last;
    logic                  w_any;
    logic [c_idx_w-1:0]    w_idx;
    logic                  w_tmo;
    logic [FPU_DATA_W-1:0] w_ops [NREQ];

    // Split the flat operand bus into one word per requester.
    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_unpack
            assign w_ops[i] = x_in[FPU_DATA_W*i +: FPU_DATA_W];
        end
    endgenerate

    fpu_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (c_idx_w)
    ) u_pick (
        .req  (req),
        .last (r_last),
        .any  (w_any),
        .idx  (w_idx)
    );

`ifdef FPU_ARB_TIMEOUT_EN
    logic [c_cnt_w-1:0] r_cnt;

    // RUN cycle counter: zero outside RUN, so every RUN entry starts at 0.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (r_state != RUN)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    // Abort on the TIMEOUT-th RUN cycle that is still stalled.
    assign w_tmo = fpu_stall && (r_cnt == c_cnt_w'(TIMEOUT - 1));

    // timeout marks the ACK cycle that follows an abort.
    always_ff @(posedge clk) begin
        if (!rst_n)
            timeout <= 1'b0;
        else
            timeout <= (r_state == RUN) && w_tmo;
    end
`else
    assign w_tmo = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic and state-decoded outputs; ack also needs req[grant]
    // so a requester that abandoned its request gets no pulse.
    always_comb begin
        w_next  = r_state;
        fpu_run = 1'b0;
        busy    = 1'b1;
        ack     = '0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_any)
                    w_next = RUN;
            end
            RUN: begin
                fpu_run = 1'b1;
                if (!fpu_stall || w_tmo)
                    w_next = ACK;
            end
            ACK: begin
                if (req[r_grant])
                    ack = NREQ'(1) << r_grant;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Grant/operand latch in IDLE, result capture (or abort clear) in RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant   <= '0;
            r_last    <= c_idx_w'(NREQ - 1);
            fpu_x     <= '0;
            z_out     <= '0;
            flags_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant <= w_idx;
                        r_last  <= w_idx;
                        fpu_x   <= w_ops[w_idx];
                    end
                end
                RUN: begin
                    if (!fpu_stall) begin
                        z_out     <= fpu_z;
                        flags_out <= fpu_flags;
                    end else if (w_tmo) begin
                        z_out     <= '0;
                        flags_out <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : fpu_arb
`default_nettype wire
